// File: rtl/ka_req_arb.sv
// Round-robin packet arbiter for the shared KA decode path: grants are held per packet
// until an EOP beat or the beat watchdog releases them; output is a registered valid/ready stage.
module ka_req_arb #(
  parameter  int NREQ     = 4,
  parameter  int DW       = 196,
  parameter  int MAXBEATS = 16,
  localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_dat,
  output logic [NREQ-1:0]      req_ready,
  output logic [DW-1:0]        t_ka_dat,
  output logic                 t_ka_valid,
  input  logic                 t_ka_ready,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 err_overrun
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [7:0]    beat_cnt_reg, beat_cnt_next;
  logic [DW-1:0] out_dat_reg, out_dat_next;
  logic          out_valid_reg, out_valid_next;
  logic          err_reg, err_next;

  logic [DW-1:0] req_word [NREQ];
  logic [DW-1:0] sel_word;
  logic          slot_free;
  logic          xfer;
  logic          sel_eop;
  logic          last_beat;
  logic [GW-1:0] grant_inc;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] pick_cand;
  int            pick_sum;

  assign slot_free = ~out_valid_reg | t_ka_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : gen_req
      assign req_word[gi]  = req_dat[gi*DW +: DW];
      assign req_ready[gi] = (state_reg == BUSY) && slot_free && (grant_reg == GW'(gi));
    end
  endgenerate

  assign sel_word  = req_word[grant_reg];
  assign sel_eop   = sel_word[DW-1];
  assign xfer      = (state_reg == BUSY) && req_valid[grant_reg] && slot_free;
  // The beat about to load is the MAXBEATS-th of this grant.
  assign last_beat = (beat_cnt_reg == 8'(MAXBEATS - 1));
  assign grant_inc = (grant_reg == GW'(NREQ - 1)) ? '0 : grant_reg + 1'b1;

  // Walk from highest offset down so the nearest requester above rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = 0;
    pick_cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pick_sum = int'(rr_ptr_reg) + k;
      if (pick_sum >= NREQ) pick_sum = pick_sum - NREQ;
      pick_cand = GW'(pick_sum);
      if (req_valid[pick_cand]) begin
        pick_found = 1'b1;
        pick_idx   = pick_cand;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    beat_cnt_next  = beat_cnt_reg;
    out_dat_next   = out_dat_reg;
    out_valid_next = out_valid_reg;
    err_next       = 1'b0;
    if (t_ka_ready) out_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next    = pick_idx;
          beat_cnt_next = '0;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          out_dat_next          = sel_word;
          out_dat_next[DW-1]    = sel_eop | last_beat;
          out_valid_next        = 1'b1;
          beat_cnt_next         = (beat_cnt_reg == 8'(MAXBEATS)) ? beat_cnt_reg
                                                                 : beat_cnt_reg + 8'd1;
          if (sel_eop || last_beat) begin
            err_next    = ~sel_eop;
            rr_ptr_next = grant_inc;
            state_next  = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      beat_cnt_reg  <= '0;
      out_dat_reg   <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      beat_cnt_reg  <= beat_cnt_next;
      out_dat_reg   <= out_dat_next;
      out_valid_reg <= out_valid_next;
      err_reg       <= err_next;
    end
  end

  assign t_ka_dat    = out_dat_reg;
  assign t_ka_valid  = out_valid_reg;
  assign grant_id    = grant_reg;
  assign busy        = (state_reg == BUSY);
  assign err_overrun = err_reg;

endmodule
